// File: rtl/dispatch.sv
// dispatch: one-entry decode-to-issue hold stage with load scoreboard; optional CIRNO_DISP_WB_BYPASS_EN
`ifndef CIRNO_DEC_OPB_SIZE
`define CIRNO_DEC_OPB_SIZE 8
`endif
`ifndef CIRNO_DEC_USELE
`define CIRNO_DEC_USELE 3
`endif
`ifndef CIRNO_DEC_SELE_ALU
`define CIRNO_DEC_SELE_ALU 0
`endif
`ifndef CIRNO_DEC_SELE_BJU
`define CIRNO_DEC_SELE_BJU 1
`endif
`ifndef CIRNO_DEC_SELE_AGU
`define CIRNO_DEC_SELE_AGU 2
`endif

module dispatch #(
   parameter int OPB_W = `CIRNO_DEC_OPB_SIZE,
   parameter int USE_W = `CIRNO_DEC_USELE
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_dec_vld,
   output logic             o_dec_rdy,
   input  logic [OPB_W-1:0] i_opb,
   input  logic [USE_W-1:0] i_usele,
   input  logic             i_rs1_ren,
   input  logic             i_rs2_ren,
   input  logic             i_rd_wen,
   input  logic [4:0]       i_rs1_idx,
   input  logic [4:0]       i_rs2_idx,
   input  logic [4:0]       i_rd_idx,
   input  logic [31:0]      i_im,
   input  logic [31:0]      i_pc,
   input  logic             i_ilgl,
   input  logic             i_ld,
   output logic             o_alu_vld,
   output logic             o_bju_vld,
   output logic             o_agu_vld,
   input  logic             i_alu_rdy,
   input  logic             i_bju_rdy,
   input  logic             i_agu_rdy,
   output logic [OPB_W-1:0] o_opb,
   output logic [4:0]       o_rs1_idx,
   output logic [4:0]       o_rs2_idx,
   output logic [4:0]       o_rd_idx,
   output logic             o_rd_wen,
   output logic [31:0]      o_im,
   output logic [31:0]      o_pc,
   input  logic             i_wb_vld,
   input  logic [4:0]       i_wb_idx,
   input  logic             i_flush,
   output logic             o_excp_vld,
   output logic [31:0]      o_excp_pc,
   output logic             o_busy
);
   logic             hold_vld, ilgl_q, ld_q, rs1_ren_q, rs2_ren_q;
   logic [USE_W-1:0] usele_q;
   logic [31:0]      sb, sb_chk, wb_mask, sb_set;
   logic             ilgl_eff, hazard, issue_ok, fire, drop, retire, accept;

   assign wb_mask = i_wb_vld ? (32'd1 << i_wb_idx) : 32'd0;
`ifdef CIRNO_DISP_WB_BYPASS_EN
   assign sb_chk = sb & ~wb_mask;
`else
   assign sb_chk = sb;
`endif
   // more than one unit selected is treated as an illegal encoding
   assign ilgl_eff = ilgl_q | (|(usele_q & (usele_q - USE_W'(1))));
   assign hazard = (rs1_ren_q & sb_chk[o_rs1_idx]) | (rs2_ren_q & sb_chk[o_rs2_idx]) | (o_rd_wen & sb_chk[o_rd_idx]);
   assign issue_ok = hold_vld & ~hazard & ~ilgl_eff & ~i_flush;
   assign o_alu_vld = issue_ok & usele_q[`CIRNO_DEC_SELE_ALU];
   assign o_bju_vld = issue_ok & usele_q[`CIRNO_DEC_SELE_BJU];
   assign o_agu_vld = issue_ok & usele_q[`CIRNO_DEC_SELE_AGU];
   assign fire = (o_alu_vld & i_alu_rdy) | (o_bju_vld & i_bju_rdy) | (o_agu_vld & i_agu_rdy);
   assign o_excp_vld = hold_vld & ilgl_eff & ~i_flush;
   assign o_excp_pc = o_pc;
   assign drop = hold_vld & ~ilgl_eff & ~i_flush & ~(|usele_q);
   assign retire = fire | o_excp_vld | drop;
   assign o_dec_rdy = (~hold_vld | retire) & ~i_flush;
   assign accept = i_dec_vld & o_dec_rdy;
   assign sb_set = (o_agu_vld & i_agu_rdy & ld_q & o_rd_wen & (|o_rd_idx)) ? (32'd1 << o_rd_idx) : 32'd0;
   assign o_busy = hold_vld | (|sb);

   // hold occupancy: flush wins, then accept refills, otherwise retire empties
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) hold_vld <= 1'b0;
      else hold_vld <= i_flush ? 1'b0 : accept ? 1'b1 : retire ? 1'b0 : hold_vld;

   // hold contents captured only on accept, so they stay stable while stalled
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_opb <= '0;
         usele_q <= '0;
         rs1_ren_q <= 1'b0;
         rs2_ren_q <= 1'b0;
         o_rd_wen <= 1'b0;
         o_rs1_idx <= '0;
         o_rs2_idx <= '0;
         o_rd_idx <= '0;
         o_im <= '0;
         o_pc <= '0;
         ilgl_q <= 1'b0;
         ld_q <= 1'b0;
      end else if (accept) begin
         o_opb <= i_opb;
         usele_q <= i_usele;
         rs1_ren_q <= i_rs1_ren;
         rs2_ren_q <= i_rs2_ren;
         o_rd_wen <= i_rd_wen;
         o_rs1_idx <= i_rs1_idx;
         o_rs2_idx <= i_rs2_idx;
         o_rd_idx <= i_rd_idx;
         o_im <= i_im;
         o_pc <= i_pc;
         ilgl_q <= i_ilgl;
         ld_q <= i_ld;
      end

   // scoreboard: load issue sets, writeback clears, set wins on collision, x0 never pending
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) sb <= '0;
      else sb <= ((sb & ~wb_mask) | sb_set) & ~32'd1;
endmodule

// File: tb/tb_dispatch.sv
// tb_dispatch: randomized and directed check of dispatch against a behavioural model
`ifndef CIRNO_DEC_OPB_SIZE
`define CIRNO_DEC_OPB_SIZE 8
`endif
`ifndef CIRNO_DEC_USELE
`define CIRNO_DEC_USELE 3
`endif
`ifndef CIRNO_DEC_SELE_ALU
`define CIRNO_DEC_SELE_ALU 0
`endif
`ifndef CIRNO_DEC_SELE_BJU
`define CIRNO_DEC_SELE_BJU 1
`endif
`ifndef CIRNO_DEC_SELE_AGU
`define CIRNO_DEC_SELE_AGU 2
`endif

module tb_dispatch;
   localparam int OPB_W = `CIRNO_DEC_OPB_SIZE;
   localparam int USE_W = `CIRNO_DEC_USELE;
   localparam int SA = `CIRNO_DEC_SELE_ALU;
   localparam int SB = `CIRNO_DEC_SELE_BJU;
   localparam int SG = `CIRNO_DEC_SELE_AGU;
   localparam logic [USE_W-1:0] U_ALU = USE_W'(1) << SA;
   localparam logic [USE_W-1:0] U_BJU = USE_W'(1) << SB;
   localparam logic [USE_W-1:0] U_AGU = USE_W'(1) << SG;
`ifdef CIRNO_DISP_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic rst_n = 1'b1;
   logic i_dec_vld, o_dec_rdy, i_rs1_ren, i_rs2_ren, i_rd_wen, i_ilgl, i_ld;
   logic [OPB_W-1:0] i_opb, o_opb;
   logic [USE_W-1:0] i_usele;
   logic [4:0] i_rs1_idx, i_rs2_idx, i_rd_idx, o_rs1_idx, o_rs2_idx, o_rd_idx, i_wb_idx;
   logic [31:0] i_im, i_pc, o_im, o_pc, o_excp_pc;
   logic o_alu_vld, o_bju_vld, o_agu_vld, i_alu_rdy, i_bju_rdy, i_agu_rdy, o_rd_wen;
   logic i_wb_vld, i_flush, o_excp_vld, o_busy;

   dispatch #(.OPB_W(OPB_W), .USE_W(USE_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_dec_vld(i_dec_vld), .o_dec_rdy(o_dec_rdy),
      .i_opb(i_opb), .i_usele(i_usele), .i_rs1_ren(i_rs1_ren), .i_rs2_ren(i_rs2_ren),
      .i_rd_wen(i_rd_wen), .i_rs1_idx(i_rs1_idx), .i_rs2_idx(i_rs2_idx), .i_rd_idx(i_rd_idx),
      .i_im(i_im), .i_pc(i_pc), .i_ilgl(i_ilgl), .i_ld(i_ld),
      .o_alu_vld(o_alu_vld), .o_bju_vld(o_bju_vld), .o_agu_vld(o_agu_vld),
      .i_alu_rdy(i_alu_rdy), .i_bju_rdy(i_bju_rdy), .i_agu_rdy(i_agu_rdy),
      .o_opb(o_opb), .o_rs1_idx(o_rs1_idx), .o_rs2_idx(o_rs2_idx), .o_rd_idx(o_rd_idx),
      .o_rd_wen(o_rd_wen), .o_im(o_im), .o_pc(o_pc), .i_wb_vld(i_wb_vld), .i_wb_idx(i_wb_idx),
      .i_flush(i_flush), .o_excp_vld(o_excp_vld), .o_excp_pc(o_excp_pc), .o_busy(o_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_err = 0;

   // model of the held instruction and the set of registers awaiting load data
   bit m_vld, m_r1, m_r2, m_wen, m_il, m_ld;
   logic [USE_W-1:0] m_use;
   logic [OPB_W-1:0] m_opb;
   int m_i1, m_i2, m_rd;
   logic [31:0] m_im, m_pc;
   bit m_sb [32];
   bit e_alu, e_bju, e_agu, e_excp, e_done, e_rdy;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit pending(int idx);
      return m_sb[idx] && !(BYP && i_wb_vld && int'(i_wb_idx) == idx);
   endfunction

   function automatic void model_out();
      int n = 0;
      bit bad, blocked, live;
      for (int k = 0; k < USE_W; k++) n += int'(m_use[k]);
      bad = m_il || n > 1;
      blocked = (m_r1 && pending(m_i1)) || (m_r2 && pending(m_i2)) || (m_wen && pending(m_rd));
      live = m_vld && !i_flush;
      e_alu = live && !bad && !blocked && m_use[SA];
      e_bju = live && !bad && !blocked && m_use[SB];
      e_agu = live && !bad && !blocked && m_use[SG];
      e_excp = live && bad;
      e_done = e_excp || (live && !bad && n == 0) || (e_alu && i_alu_rdy) || (e_bju && i_bju_rdy) || (e_agu && i_agu_rdy);
      e_rdy = !i_flush && (!m_vld || e_done);
   endfunction

   function automatic void model_upd();
      int dst = 0;
      if (e_agu && i_agu_rdy && m_ld && m_wen && m_rd != 0) dst = m_rd;
      if (i_wb_vld) m_sb[int'(i_wb_idx)] = 1'b0;
      if (dst != 0) m_sb[dst] = 1'b1;
      if (i_flush) m_vld = 1'b0;
      else if (i_dec_vld && e_rdy) begin
         m_vld = 1'b1;
         m_use = i_usele;
         m_opb = i_opb;
         m_r1 = i_rs1_ren;
         m_r2 = i_rs2_ren;
         m_wen = i_rd_wen;
         m_i1 = int'(i_rs1_idx);
         m_i2 = int'(i_rs2_idx);
         m_rd = int'(i_rd_idx);
         m_im = i_im;
         m_pc = i_pc;
         m_il = i_ilgl;
         m_ld = i_ld;
      end else if (e_done) m_vld = 1'b0;
   endfunction

   function automatic logic [31:0] sb_exp();
      logic [31:0] v = '0;
      for (int k = 0; k < 32; k++) v[k] = m_sb[k];
      return v;
   endfunction

   task automatic step();
      bit any;
      @(negedge clk);
      model_out();
      any = 1'b0;
      for (int k = 0; k < 32; k++) any |= m_sb[k];
      chk("dec_rdy", o_dec_rdy, e_rdy);
      chk("alu_vld", o_alu_vld, e_alu);
      chk("bju_vld", o_bju_vld, e_bju);
      chk("agu_vld", o_agu_vld, e_agu);
      chk("excp_vld", o_excp_vld, e_excp);
      chk("busy", o_busy, m_vld || any);
      chk("sb", dut.sb, sb_exp());
      if (e_excp) chk("excp_pc", o_excp_pc, m_pc);
      if (m_vld) begin
         chk("bus_opb", o_opb, m_opb);
         chk("bus_rs1", o_rs1_idx, m_i1);
         chk("bus_rs2", o_rs2_idx, m_i2);
         chk("bus_rd", o_rd_idx, m_rd);
         chk("bus_wen", o_rd_wen, m_wen);
         chk("bus_im", o_im, m_im);
         chk("bus_pc", o_pc, m_pc);
      end
      @(posedge clk);
      model_upd();
      #1;
   endtask

   task automatic idle();
      i_dec_vld = 1'b0;
      i_usele = '0;
      i_rs1_ren = 1'b0;
      i_rs2_ren = 1'b0;
      i_rd_wen = 1'b0;
      i_rs1_idx = '0;
      i_rs2_idx = '0;
      i_rd_idx = '0;
      i_im = '0;
      i_pc = '0;
      i_opb = '0;
      i_ilgl = 1'b0;
      i_ld = 1'b0;
      i_alu_rdy = 1'b1;
      i_bju_rdy = 1'b1;
      i_agu_rdy = 1'b1;
      i_wb_vld = 1'b0;
      i_wb_idx = '0;
      i_flush = 1'b0;
   endtask

   task automatic put(input logic [USE_W-1:0] u, input int rd, input int r1, input int r2,
                      input bit wen, input bit ld, input bit il, input logic [31:0] pc);
      i_dec_vld = 1'b1;
      i_usele = u;
      i_rd_idx = 5'(rd);
      i_rs1_idx = 5'(r1);
      i_rs2_idx = 5'(r2);
      i_rs1_ren = r1 != 0;
      i_rs2_ren = r2 != 0;
      i_rd_wen = wen;
      i_ld = ld;
      i_ilgl = il;
      i_pc = pc;
      i_im = $urandom;
      i_opb = OPB_W'($urandom);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      #2;
      m_vld = 1'b0;
      m_use = '0;
      for (int k = 0; k < 32; k++) m_sb[k] = 1'b0;
      chk("rst_busy", o_busy, 0);
      chk("rst_alu", o_alu_vld, 0);
      chk("rst_bju", o_bju_vld, 0);
      chk("rst_agu", o_agu_vld, 0);
      chk("rst_excp", o_excp_vld, 0);
      chk("rst_rdy", o_dec_rdy, 1);
      chk("rst_pc", o_pc, 0);
      chk("rst_rd", o_rd_idx, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      #1;
      do_reset();
      // back-to-back ALU stream
      put(U_ALU, 1, 0, 0, 1, 0, 0, 32'h0);
      step();
      for (int k = 2; k <= 5; k++) begin
         put(U_ALU, k, 0, 0, 1, 0, 0, 32'(4 * k));
         #2;
         chk("stream_alu", o_alu_vld, 1);
         chk("stream_rd", o_rd_idx, k - 1);
         chk("stream_rdy", o_dec_rdy, 1);
         step();
      end
      idle();
      step();
      step();
      // load-use hazard released by writeback
      put(U_AGU, 5, 2, 0, 1, 1, 0, 32'h10);
      step();
      put(U_ALU, 6, 5, 2, 1, 0, 0, 32'h14);
      #2;
      chk("lu_agu", o_agu_vld, 1);
      step();
      idle();
      for (int k = 0; k < 2; k++) begin
         #2;
         chk("lu_held", o_alu_vld, 0);
         step();
      end
      i_wb_vld = 1'b1;
      i_wb_idx = 5'd5;
      #2;
      chk("lu_wb_cycle", o_alu_vld, BYP);
      step();
      i_wb_vld = 1'b0;
      #2;
      chk("lu_after_wb", o_alu_vld, !BYP);
      step();
      step();
      // branch stalled by busy BJU
      put(U_BJU, 0, 3, 4, 0, 0, 0, 32'h40);
      i_bju_rdy = 1'b0;
      step();
      put(U_ALU, 8, 0, 0, 1, 0, 0, 32'h44);
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("br_vld", o_bju_vld, 1);
         chk("br_pc", o_pc, 32'h40);
         chk("br_rdy", o_dec_rdy, 0);
         step();
      end
      i_bju_rdy = 1'b1;
      #2;
      chk("br_fire", o_bju_vld, 1);
      chk("br_fire_rdy", o_dec_rdy, 1);
      step();
      idle();
      step();
      step();
      // illegal instruction
      put(U_ALU, 9, 0, 0, 1, 0, 1, 32'h80);
      step();
      idle();
      #2;
      chk("il_excp", o_excp_vld, 1);
      chk("il_pc", o_excp_pc, 32'h80);
      chk("il_alu", o_alu_vld, 0);
      step();
      #2;
      chk("il_once", o_excp_vld, 0);
      step();
      // empty unit select is dropped
      put('0, 3, 0, 0, 1, 0, 0, 32'h90);
      step();
      idle();
      step();
      #2;
      chk("drop_busy", o_busy, 0);
      step();
      // flush with pending scoreboard entry
      put(U_AGU, 5, 0, 0, 1, 1, 0, 32'hA0);
      step();
      put(U_ALU, 6, 5, 0, 1, 0, 0, 32'hA4);
      step();
      idle();
      i_flush = 1'b1;
      #2;
      chk("fl_no_vld", o_alu_vld, 0);
      chk("fl_rdy", o_dec_rdy, 0);
      step();
      i_flush = 1'b0;
      #2;
      chk("fl_busy", o_busy, 1);
      chk("fl_sb5", dut.sb[5], 1);
      chk("fl_cleared", o_alu_vld, 0);
      step();
      i_wb_vld = 1'b1;
      i_wb_idx = 5'd5;
      step();
      idle();
      // load set and writeback clear on the same register in one cycle
      put(U_AGU, 7, 0, 0, 1, 1, 0, 32'hB0);
      step();
      idle();
      i_wb_vld = 1'b1;
      i_wb_idx = 5'd7;
      #2;
      chk("sw_agu", o_agu_vld, 1);
      step();
      i_wb_vld = 1'b0;
      #2;
      chk("sw_sb7", dut.sb[7], 1);
      step();
      i_wb_vld = 1'b1;
      step();
      idle();
      // reset while a branch is stalled
      put(U_BJU, 0, 1, 0, 0, 0, 0, 32'hC0);
      i_bju_rdy = 1'b0;
      step();
      #2;
      chk("mr_vld", o_bju_vld, 1);
      do_reset();
      step();
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int r = int'($urandom_range(0, 9));
         logic [USE_W-1:0] u;
         u = r < 4 ? U_ALU : r < 6 ? U_BJU : r < 9 ? U_AGU : ($urandom_range(0, 1) != 0 ? '0 : (U_ALU | U_AGU));
         put(u, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), (u == U_AGU) && ($urandom_range(0, 2) != 0), $urandom_range(0, 15) == 0,
             $urandom);
         i_dec_vld = $urandom_range(0, 3) != 0;
         i_alu_rdy = $urandom_range(0, 3) != 0;
         i_bju_rdy = $urandom_range(0, 3) != 0;
         i_agu_rdy = $urandom_range(0, 3) != 0;
         i_wb_vld = $urandom_range(0, 2) == 0;
         i_wb_idx = 5'($urandom_range(0, 7));
         i_flush = $urandom_range(0, 24) == 0;
         if (c == 1500) do_reset();
         else step();
      end
      idle();
      step();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
